// File: rtl/pipe_pkg.sv
// Shared MEM-stage definitions: funct3 encodings, FSM states and the bubble instruction.
package pipe_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {IDLE, WAIT_RESP} mem_state_e;
endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores, lane extraction plus extension for loads, and
// illegal/misaligned detection. Purely combinational.
module mem_align
    import pipe_pkg::*;
(
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] store_data_i,
    input  logic [2:0]  ext_funct3_i,
    input  logic [1:0]  ext_offset_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o,
    output logic        illegal_o,
    output logic        misaligned_o,
    output logic [31:0] load_data_o
);
    logic [31:0] lane;

    always_comb begin
        illegal_o = 1'b0;
        if (is_store_i)
            illegal_o = !(funct3_i inside {F3_B, F3_H, F3_W});
        else if (is_load_i)
            illegal_o = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned_o = ((funct3_i[1:0] == 2'b01) && offset_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (offset_i != 2'b00));
    end

    always_comb begin
        mask_o  = 4'b1111;
        wdata_o = '0;
        if (is_store_i) begin
            case (funct3_i)
                F3_B: begin
                    mask_o  = 4'b0001 << offset_i;
                    wdata_o = {4{store_data_i[7:0]}};
                end
                F3_H: begin
                    mask_o  = offset_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{store_data_i[15:0]}};
                end
                default: wdata_o = store_data_i;
            endcase
        end
    end

    always_comb begin
        lane = rdata_i >> {ext_offset_i, 3'b000};
        case (ext_funct3_i)
            F3_B:    load_data_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_data_o = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   load_data_o = {24'h0, lane[7:0]};
            F3_HU:   load_data_o = {16'h0, lane[15:0]};
            default: load_data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake, load/store alignment and the MEM/WB
// register. Upstream is held via o_stall while an access is outstanding.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_rs2_rdata,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus_4,
    input  logic [31:0]     i_instruction,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic            i_reg_write,
    input  logic            i_mem_to_reg,
    input  logic            i_jump,
    input  logic            i_retire_halt,
    output logic            o_stall,
    output logic            o_dmem_req,
    output logic            o_dmem_wen,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_mask,
    input  logic            i_dmem_ready,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_valid,
    output logic            o_reg_write,
    output logic            o_trap,
    output logic            o_retire_halt,
    output logic [XLEN-1:0] o_wb_data,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_instruction
);
    mem_state_e  state_q, state_d;
    logic [2:0]  ld_f3_q;
    logic [1:0]  ld_off_q;

    logic        valid_q, reg_write_q, trap_q, halt_q;
    logic [31:0] wb_data_q, pc_q, instr_q;
    logic [4:0]  rd_q;

    logic        mem_op, is_store, is_load, illegal, misaligned, fault, req, stall;
    logic [2:0]  funct3, ext_f3;
    logic [1:0]  offset, ext_off;
    logic [31:0] load_data, wb_sel, wdata;
    logic [3:0]  mask;

    assign funct3   = i_instruction[14:12];
    assign offset   = i_alu_result[1:0];
    assign mem_op   = i_valid & (i_mem_read | i_mem_write);
    assign is_store = mem_op & i_mem_write;
    assign is_load  = mem_op & ~i_mem_write;
    assign fault    = mem_op & (illegal | misaligned);

    // Once the load is accepted, extraction uses the latched lane info.
    assign ext_f3  = (state_q == WAIT_RESP) ? ld_f3_q  : funct3;
    assign ext_off = (state_q == WAIT_RESP) ? ld_off_q : offset;

    mem_align u_align (
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .funct3_i     (funct3),
        .offset_i     (offset),
        .store_data_i (i_rs2_rdata),
        .ext_funct3_i (ext_f3),
        .ext_offset_i (ext_off),
        .rdata_i      (i_dmem_rdata),
        .mask_o       (mask),
        .wdata_o      (wdata),
        .illegal_o    (illegal),
        .misaligned_o (misaligned),
        .load_data_o  (load_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req && i_dmem_ready && is_load) state_d = WAIT_RESP;
            WAIT_RESP: if (i_dmem_rvalid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        req   = 1'b0;
        stall = 1'b0;
        if (!i_rst) begin
            case (state_q)
                IDLE: begin
                    req   = mem_op & ~fault;
                    stall = req & (~i_dmem_ready | is_load);
                end
                WAIT_RESP: stall = ~i_dmem_rvalid;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ld_f3_q  <= '0;
            ld_off_q <= '0;
        end else if (state_q == IDLE && req && i_dmem_ready && is_load) begin
            ld_f3_q  <= funct3;
            ld_off_q <= offset;
        end
    end

    assign wb_sel = i_mem_to_reg ? load_data : (i_jump ? i_pc_plus_4 : i_alu_result);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            trap_q      <= 1'b0;
            halt_q      <= 1'b0;
            wb_data_q   <= '0;
            rd_q        <= '0;
            pc_q        <= '0;
            instr_q     <= NOP_INSTR;
        end else if (stall) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            trap_q      <= 1'b0;
            halt_q      <= 1'b0;
            instr_q     <= NOP_INSTR;
        end else begin
            valid_q     <= i_valid;
            reg_write_q <= i_valid & i_reg_write & ~fault;
            trap_q      <= fault;
            halt_q      <= i_valid & i_retire_halt;
            wb_data_q   <= wb_sel;
            rd_q        <= i_rd_addr;
            pc_q        <= i_pc;
            instr_q     <= i_valid ? i_instruction : NOP_INSTR;
        end
    end

    assign o_stall       = stall;
    assign o_dmem_req    = req;
    assign o_dmem_wen    = req & is_store;
    assign o_dmem_addr   = {i_alu_result[XLEN-1:2], 2'b00};
    assign o_dmem_wdata  = wdata;
    assign o_dmem_mask   = mask;
    assign o_valid       = valid_q;
    assign o_reg_write   = reg_write_q;
    assign o_trap        = trap_q;
    assign o_retire_halt = halt_q;
    assign o_wb_data     = wb_data_q;
    assign o_rd_addr     = rd_q;
    assign o_pc          = pc_q;
    assign o_instruction = instr_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: behavioural model checked every cycle plus literal spot checks.
module tb_mem_stage;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0, rst = 1'b1;
    logic        valid = 0, mem_read = 0, mem_write = 0, reg_write = 0, mem_to_reg = 0;
    logic        jump = 0, halt = 0, ready = 1, rvalid = 0;
    logic [31:0] alu = 0, rs2 = 0, pc = 0, pc4 = 0, instr = NOP, rdata = 0;
    logic [4:0]  rd = 0;

    logic        stall, req, wen, o_valid, o_rw, o_trap, o_halt;
    logic [31:0] addr, wdata, wb, o_pc, o_instr;
    logic [3:0]  mask;
    logic [4:0]  o_rd;

    int total = 0, bad = 0;
    bit chk_en = 0;

    mem_stage dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_alu_result(alu), .i_rs2_rdata(rs2),
        .i_pc(pc), .i_pc_plus_4(pc4), .i_instruction(instr), .i_rd_addr(rd),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_reg_write(reg_write),
        .i_mem_to_reg(mem_to_reg), .i_jump(jump), .i_retire_halt(halt),
        .o_stall(stall), .o_dmem_req(req), .o_dmem_wen(wen), .o_dmem_addr(addr),
        .o_dmem_wdata(wdata), .o_dmem_mask(mask), .i_dmem_ready(ready),
        .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata), .o_valid(o_valid),
        .o_reg_write(o_rw), .o_trap(o_trap), .o_retire_halt(o_halt), .o_wb_data(wb),
        .o_rd_addr(o_rd), .o_pc(o_pc), .o_instruction(o_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_fault(input logic mw, input logic [2:0] f3, input logic [1:0] off);
        bit legal;
        legal = mw ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || (int'(off) % nbytes(f3) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        longint v, span;
        v = longint'(w >> (8 * int'(off)));
        if (nbytes(f3) < 4) begin
            span = longint'(1) << (8 * nbytes(f3));
            v = v % span;
            if (f3 < 3'd4 && v >= span / 2) v = v - span;
        end
        return v[31:0];
    endfunction

    bit          pend = 0;
    logic        e_valid, e_rw, e_trap, e_halt;
    logic [31:0] e_wb, e_pc, e_instr;
    logic [4:0]  e_rd;

    function automatic void m_comb(output bit r, output bit s);
        bit op;
        op = valid && (mem_read || mem_write);
        r = 0; s = 0;
        if (rst) return;
        if (pend) s = !rvalid;
        else begin
            r = op && !m_fault(mem_write, instr[14:12], alu[1:0]);
            s = r && (!ready || !mem_write);
        end
    endfunction

    always @(posedge clk) begin
        bit r, s, f;
        m_comb(r, s);
        f = valid && (mem_read || mem_write) && m_fault(mem_write, instr[14:12], alu[1:0]);
        if (rst) begin
            pend = 0; e_valid = 0; e_rw = 0; e_trap = 0; e_halt = 0;
            e_wb = 0; e_pc = 0; e_rd = 0; e_instr = NOP;
        end else if (s) begin
            if (!pend && r && ready && !mem_write) pend = 1;
            e_valid = 0; e_rw = 0; e_trap = 0; e_halt = 0; e_instr = NOP;
        end else begin
            pend    = 0;
            e_valid = valid;
            e_trap  = f;
            e_rw    = valid && reg_write && !f;
            e_halt  = valid && halt;
            e_wb    = mem_to_reg ? m_load(rdata, instr[14:12], alu[1:0]) : (jump ? pc4 : alu);
            e_pc    = pc;
            e_rd    = rd;
            e_instr = valid ? instr : NOP;
        end
    end

    always @(negedge clk) if (chk_en) begin
        bit r, s;
        int n;
        m_comb(r, s);
        chk("req", 32'(req), 32'(r));
        chk("stall", 32'(stall), 32'(s));
        if (r) begin
            n = nbytes(instr[14:12]);
            chk("wen", 32'(wen), 32'(mem_write));
            chk("addr", addr, {alu[31:2], 2'b00});
            if (mem_write) begin
                chk("mask", 32'(mask), ((1 << n) - 1) << alu[1:0]);
                chk("wdata", wdata, n == 1 ? rs2[7:0] * 32'h01010101 :
                                    n == 2 ? rs2[15:0] * 32'h00010001 : rs2);
            end else begin
                chk("mask", 32'(mask), 32'hF);
                chk("wdata", wdata, 32'h0);
            end
        end
        chk("o_valid", 32'(o_valid), 32'(e_valid));
        chk("o_reg_write", 32'(o_rw), 32'(e_rw));
        chk("o_trap", 32'(o_trap), 32'(e_trap));
        chk("o_retire_halt", 32'(o_halt), 32'(e_halt));
        chk("o_instruction", o_instr, e_instr);
        if (e_valid && !e_trap) begin
            chk("o_pc", o_pc, e_pc);
            chk("o_rd_addr", 32'(o_rd), 32'(e_rd));
            chk("o_wb_data", wb, e_wb);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        valid = 0; mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0; jump = 0;
        instr = NOP;
    endtask

    task automatic mem(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
        valid = 1; mem_read = ld; mem_write = st; reg_write = ld; mem_to_reg = ld; jump = 0;
        alu = a; rs2 = d; pc = pc + 4; pc4 = pc + 4; rd = ld ? 5'd7 : 5'd0;
        instr = {17'h0, f3, rd, st ? 7'h23 : 7'h03};
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        chk("rst o_instruction", o_instr, NOP);
        chk("rst o_valid", 32'(o_valid), 32'h0);
        rst = 0;

        // SW 0x100
        mem(0, 1, 3'b010, 32'h100, 32'hDEADBEEF); #1;
        chk("sw mask", 32'(mask), 32'hF);
        chk("sw addr", addr, 32'h100);
        chk("sw stall", 32'(stall), 32'h0);
        step(); idle();
        chk("sw retire valid", 32'(o_valid), 32'h1);
        chk("sw retire rw", 32'(o_rw), 32'h0);

        // SB 0x103
        mem(0, 1, 3'b000, 32'h103, 32'h000000AB); #1;
        chk("sb mask", 32'(mask), 32'h8);
        chk("sb wdata", wdata, 32'hABABABAB);
        step(); idle();

        // SH 0x102 with one cycle of backpressure
        ready = 0; mem(0, 1, 3'b001, 32'h102, 32'h0000BEEF); #1;
        chk("sh mask", 32'(mask), 32'hC);
        step(); ready = 1;
        step(); idle();

        // LB / LBU at 0x102, rvalid 3 cycles after accept
        for (int k = 0; k < 2; k++) begin
            rdata = 32'h12F45678;
            mem(1, 0, k == 0 ? 3'b000 : 3'b100, 32'h102, 32'h0);
            step();
            chk("ld bubble", 32'(o_valid), 32'h0);
            step(); step();
            rvalid = 1; #1;
            chk("ld stall release", 32'(stall), 32'h0);
            step(); rvalid = 0; idle();
            chk("ld wb", wb, k == 0 ? 32'hFFFFFFF4 : 32'h000000F4);
            chk("ld valid", 32'(o_valid), 32'h1);
        end

        // LW misaligned -> trap, no request
        mem(1, 0, 3'b010, 32'h102, 32'h0); #1;
        chk("lw mis req", 32'(req), 32'h0);
        step(); idle();
        chk("lw mis trap", 32'(o_trap), 32'h1);
        chk("lw mis rw", 32'(o_rw), 32'h0);

        // Illegal store funct3 -> trap
        mem(0, 1, 3'b011, 32'h200, 32'h1); step(); idle();
        chk("illegal trap", 32'(o_trap), 32'h1);

        // LH with ready low for 2 cycles
        ready = 0; rdata = 32'h00008001;
        mem(1, 0, 3'b001, 32'h100, 32'h0);
        step(); step(); ready = 1;
        step(); rvalid = 1;
        step(); rvalid = 0; idle();
        chk("lh wb", wb, 32'hFFFF8001);

        // LH again, reset during WAIT_RESP, late rvalid ignored
        mem(1, 0, 3'b001, 32'h100, 32'h0);
        step(); rst = 1;
        step(); rst = 0; idle(); rvalid = 1;
        chk("rst mid instr", o_instr, NOP);
        chk("rst mid valid", 32'(o_valid), 32'h0);
        step(); rvalid = 0;
        chk("late rvalid valid", 32'(o_valid), 32'h0);
        chk("late rvalid rw", 32'(o_rw), 32'h0);

        // JAL
        valid = 1; reg_write = 1; jump = 1; pc = 32'h20; pc4 = 32'h24; alu = 32'h80;
        rd = 5'd1; instr = 32'h0000006F; halt = 0; #1;
        chk("jal req", 32'(req), 32'h0);
        step(); idle();
        chk("jal wb", wb, 32'h24);
        chk("jal rw", 32'(o_rw), 32'h1);

        step(); step();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
